// File: rtl/debug_capture.sv
// Change-capture debugger: flags masked changes on a probe bus and logs each one
// as a {timestamp, value} event in a FIFO drained over a valid/ready stream.
module debug_capture #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          w,
    input  logic [WIDTH-1:0]          mask,
    input  logic                      arm,
    input  logic                      clear,
    output logic                      trigger,
    output logic [WIDTH-1:0]          data,
    output logic                      ev_valid,
    input  logic                      ev_ready,
    output logic [TS_WIDTH+WIDTH-1:0] ev_data,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0]          r_data;
    logic                      r_trig;
    logic                      r_ovf;
    logic [TS_WIDTH-1:0]       r_ts;
    logic [LW-1:0]             r_level;
    logic [AW-1:0]             r_wr;
    logic [AW-1:0]             r_rd;
    logic [TS_WIDTH+WIDTH-1:0] r_mem [DEPTH];

    logic w_chg;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_drop;

    assign w_chg      = |((w ^ r_data) & mask);
    assign w_full     = (r_level == LW'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_pop      = !w_empty && ev_ready && !clear;
    assign w_push_req = w_chg && arm && !clear;
    // A full FIFO still accepts a push when the head is leaving in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_trig  <= 1'b0;
            r_ovf   <= 1'b0;
            r_ts    <= '0;
            r_level <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
        end else begin
            r_data <= w;
            r_trig <= w_chg;
            if (clear) begin
                r_ovf   <= 1'b0;
                r_ts    <= '0;
                r_level <= '0;
                r_wr    <= '0;
                r_rd    <= '0;
            end else begin
                r_ts <= r_ts + 1'b1;
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                if (w_push) begin
                    r_wr <= r_wr + 1'b1;
                end
                if (w_pop) begin
                    r_rd <= r_rd + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - 1'b1;
                end
            end
        end
    end

    // Event storage carries no reset; emptiness is tracked solely by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {r_ts, w};
        end
    end

    assign trigger  = r_trig;
    assign data     = r_data;
    assign overflow = r_ovf;
    assign level    = r_level;
    assign ev_valid = !w_empty;
    assign ev_data  = ev_valid ? r_mem[r_rd] : '0;

endmodule

// File: tb/tb_debug_capture.sv
// Randomised and directed bench for debug_capture, checked against a queue-based
// model of the capture/FIFO behaviour.
module tb_debug_capture;
    localparam int W   = 8;
    localparam int D   = 16;
    localparam int TSW = 16;
    localparam int LW  = $clog2(D) + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [W-1:0]     w = '0;
    logic [W-1:0]     mask = '0;
    logic             arm = 1'b0;
    logic             clear = 1'b0;
    logic             ev_ready = 1'b0;
    logic             trigger;
    logic [W-1:0]     data;
    logic             ev_valid;
    logic [TSW+W-1:0] ev_data;
    logic [LW-1:0]    level;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]     m_data;
    logic             m_trig;
    logic             m_ovf;
    logic [TSW-1:0]   m_ts;
    logic [TSW+W-1:0] m_q[$];

    debug_capture #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TSW)) dut (
        .clk(clk), .reset_n(reset_n), .w(w), .mask(mask), .arm(arm), .clear(clear),
        .trigger(trigger), .data(data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_data(ev_data), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0;
        m_trig = 1'b0;
        m_ovf  = 1'b0;
        m_ts   = '0;
        m_q.delete();
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".trigger"}, 64'(trigger), 64'(m_trig));
        check_eq({tag, ".data"}, 64'(data), 64'(m_data));
        check_eq({tag, ".ev_valid"}, 64'(ev_valid), 64'(m_q.size() != 0));
        check_eq({tag, ".level"}, 64'(level), 64'(m_q.size()));
        check_eq({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        check_eq({tag, ".ev_data"}, 64'(ev_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
    endtask

    // Advance the model by one clock using the inputs currently driven, then compare.
    task automatic step(input string tag);
        logic chg;
        logic pop;
        logic [TSW+W-1:0] entry;
        chg   = |((w ^ m_data) & mask);
        entry = {m_ts, w};
        if (clear) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_ts  = '0;
        end else begin
            pop = (m_q.size() != 0) && ev_ready;
            if (pop) void'(m_q.pop_front());
            if (chg && arm) begin
                if (m_q.size() >= D) m_ovf = 1'b1;
                else m_q.push_back(entry);
            end
            m_ts = m_ts + 1'b1;
        end
        m_data = w;
        m_trig = chg;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step("clear");
        clear = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #4 reset_n = 1'b1;

        // First event at ts = 5
        mask = 8'hFF; arm = 1'b1; ev_ready = 1'b0; w = 8'h00;
        repeat (5) step("idle");
        w = 8'hA5;
        step("first");
        check_eq("first.ev_data_const", 64'(ev_data), 64'h0005A5);
        check_eq("first.trigger_const", 64'(trigger), 64'd1);
        step("first_hold");
        check_eq("first.trigger_pulse", 64'(trigger), 64'd0);

        // Masked-off bit change, then an enabled one
        mask = 8'h0F;
        w = w ^ 8'h80;
        step("masked_off");
        check_eq("masked_off.level", 64'(level), 64'd1);
        w = w ^ 8'h01;
        step("masked_on");
        check_eq("masked_on.level", 64'(level), 64'd2);

        // Overflow with 17 changes, then drain
        mask = 8'hFF;
        do_clear();
        for (int i = 0; i < 17; i++) begin
            w = 8'h30 + 8'(i);
            step("fill17");
        end
        check_eq("fill17.level_const", 64'(level), 64'd16);
        check_eq("fill17.ovf_const", 64'(overflow), 64'd1);
        ev_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_eq("drain.order", 64'(ev_data[W-1:0]), 64'(8'h30 + 8'(i)));
            step("drain");
        end
        check_eq("drain.ovf_sticky", 64'(overflow), 64'd1);
        ev_ready = 1'b0;

        // Full FIFO with simultaneous push and pop
        do_clear();
        for (int i = 0; i < 16; i++) begin
            w = 8'h50 + 8'(i);
            step("fill16");
        end
        ev_ready = 1'b1;
        w = 8'hEE;
        step("full_pushpop");
        check_eq("full_pushpop.level", 64'(level), 64'd16);
        check_eq("full_pushpop.ovf", 64'(overflow), 64'd0);
        check_eq("full_pushpop.head", 64'(ev_data[W-1:0]), 64'h51);
        ev_ready = 1'b0;

        // Disarmed changes, then clear with level 3
        do_clear();
        for (int i = 1; i <= 3; i++) begin
            w = 8'(i);
            step("armed");
        end
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'hC0 + 8'(i);
            step("disarmed");
        end
        check_eq("disarmed.level", 64'(level), 64'd3);
        clear = 1'b1;
        step("clear3");
        clear = 1'b0;
        check_eq("clear3.level", 64'(level), 64'd0);
        check_eq("clear3.ev_valid", 64'(ev_valid), 64'd0);
        arm = 1'b1;
        w = 8'h77;
        step("after_clear");
        check_eq("after_clear.ts", 64'(ev_data[TSW+W-1:W]), 64'd0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) w = W'($urandom);
            if (i % 50 == 0) mask = W'($urandom) | 8'h01;
            arm      = ($urandom_range(0, 3) != 0);
            ev_ready = ($urandom_range(0, 2) == 0);
            clear    = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        clear = 1'b0;

        // Async reset mid-drain with level 5
        mask = 8'hFF; arm = 1'b1; ev_ready = 1'b0;
        do_clear();
        for (int i = 0; i < 5; i++) begin
            w = 8'h90 + 8'(i);
            step("prefill5");
        end
        check_eq("prefill5.level", 64'(level), 64'd5);
        ev_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2 reset_n = 1'b1;
        ev_ready = 1'b1;
        for (int i = 0; i < 6; i++) step("post_reset");
        w = 8'h3C;
        step("post_reset_ev");
        step("post_reset_pop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
